// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and defaults for the PLL reset/lock supervisor.
// Holds the FSM state enum, the registered output bundle and the counter sizing helper.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_PRST = 3'd0,
    ST_WAIT = 3'd1,
    ST_STAB = 3'd2,
    ST_RUN  = 3'd3,
    ST_FAIL = 3'd4
  } pll_sup_state_t;

  typedef struct packed {
    logic pll_reset;
    logic rst_out;
    logic pll_ready;
    logic fail;
  } pll_sup_out_t;

  localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_MAX_RETRIES         = 7;

  // Width of the shared cycle counter: enough for the largest terminal count.
  function automatic int cnt_width(input int unsigned a, input int unsigned b,
                                   input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

  // Output decode for a state; applied at the transition so outputs move with the state.
  function automatic pll_sup_out_t state_outs(input pll_sup_state_t s);
    pll_sup_out_t o;
    o.pll_reset = (s == ST_PRST);
    o.rst_out   = (s != ST_RUN);
    o.pll_ready = (s == ST_RUN);
    o.fail      = (s == ST_FAIL);
    return o;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Supervisor <-> PLL/system signal bundle.
// The master side is the supervisor; the slave side is the PLL and the reset consumers.
interface pll_lock_supervisor_if;
  logic       lock;
  logic       pll_reset;
  logic       rst_out;
  logic       pll_ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  modport master (
    input  lock,
    output pll_reset,
    output rst_out,
    output pll_ready,
    output fail,
    output retry_cnt,
    output loss_cnt
  );

  modport slave (
    output lock,
    input  pll_reset,
    input  rst_out,
    input  pll_ready,
    input  fail,
    input  retry_cnt,
    input  loss_cnt
  );
endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Generic two-flop synchroniser, one independent chain per bit.
// Bits are not coherent with each other; use only for independent level signals.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk) begin
        if (srst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= d[gi];
          sync_reg <= meta_reg;
        end
      end

      assign q[gi] = sync_reg;
    end
  endgenerate

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor on the reference clock: pulses the PLL reset, waits for a
// stable lock, releases the system reset, retries failed attempts and re-inits on lock loss.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                   clkin,
  input  logic                   reset,
  pll_lock_supervisor_if.master  sup
);

  localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

  logic            lock_s;
  pll_sup_state_t  state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [3:0]      retry_reg;
  logic [7:0]      loss_reg;
  pll_sup_out_t    out_reg;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk  (clkin),
    .srst (reset),
    .d    (sup.lock),
    .q    (lock_s)
  );

  // Outputs are reloaded only on a state change, so they always match state_reg.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_reg <= ST_PRST;
      cnt_reg   <= '0;
      retry_reg <= '0;
      loss_reg  <= '0;
      out_reg   <= state_outs(ST_PRST);
    end else begin
      unique case (state_reg)
        ST_PRST: begin
          if (cnt_reg == RST_LAST) begin
            state_reg <= ST_WAIT;
            out_reg   <= state_outs(ST_WAIT);
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        // A lock seen on the timeout cycle still wins over the retry.
        ST_WAIT: begin
          if (lock_s) begin
            state_reg <= ST_STAB;
            out_reg   <= state_outs(ST_STAB);
            cnt_reg   <= '0;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            if (retry_reg == RETRY_LIMIT) begin
              state_reg <= ST_FAIL;
              out_reg   <= state_outs(ST_FAIL);
            end else begin
              retry_reg <= retry_reg + 4'd1;
              state_reg <= ST_PRST;
              out_reg   <= state_outs(ST_PRST);
              cnt_reg   <= '0;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        // Any dropout restarts the lock wait without consuming a retry.
        ST_STAB: begin
          if (!lock_s) begin
            state_reg <= ST_WAIT;
            out_reg   <= state_outs(ST_WAIT);
            cnt_reg   <= '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_reg <= ST_RUN;
            out_reg   <= state_outs(ST_RUN);
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        ST_RUN: begin
          if (!lock_s) begin
            state_reg <= ST_PRST;
            out_reg   <= state_outs(ST_PRST);
            cnt_reg   <= '0;
            retry_reg <= '0;
            if (loss_reg != 8'hFF) begin
              loss_reg <= loss_reg + 8'd1;
            end
          end
        end

        ST_FAIL: begin
        end

        default: begin
          state_reg <= ST_PRST;
          out_reg   <= state_outs(ST_PRST);
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign sup.pll_reset = out_reg.pll_reset;
  assign sup.rst_out   = out_reg.rst_out;
  assign sup.pll_ready = out_reg.pll_ready;
  assign sup.fail      = out_reg.fail;
  assign sup.retry_cnt = retry_reg;
  assign sup.loss_cnt  = loss_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: expected status words are queued per cycle
// as stimulus is applied and compared when the run reaches that cycle.
module tb_pll_lock_supervisor;

  logic clkin;
  logic reset;

  pll_lock_supervisor_if sup ();

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2)
  ) dut (
    .clkin (clkin),
    .reset (reset),
    .sup   (sup)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  typedef struct {
    string       tag;
    int          cyc;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   vectors;
  int   miscompares;

  // Status word: {pll_reset, rst_out, pll_ready, fail, retry_cnt[3:0], loss_cnt[7:0]}
  function automatic logic [15:0] st(input logic pr, input logic ro, input logic rdy,
                                     input logic f, input int rc, input int lc);
    return {pr, ro, rdy, f, 4'(rc), 8'(lc)};
  endfunction

  task automatic push(input string tag, input int c, input logic [15:0] e);
    exp_t x;
    x.tag = tag;
    x.cyc = c;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic consume();
    logic [15:0] obs;
    exp_t        e;
    obs = {sup.pll_reset, sup.rst_out, sup.pll_ready, sup.fail, sup.retry_cnt, sup.loss_cnt};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      vectors++;
      assert (e.cyc == cyc && obs === e.exp)
      else begin
        miscompares++;
        $error("FAIL %s: cycle %0d (wanted %0d) observed %h expected %h",
               e.tag, cyc, e.cyc, obs, e.exp);
      end
      $display("vec %0d %s cyc %0d status %h", vectors, e.tag, cyc, obs);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) begin
      tick();
      cyc++;
      consume();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sup.lock = 1'b0;
    push("reset_vals", 0, st(1, 1, 0, 0, 0, 0));
    tick();
    tick();
    reset = 1'b0;
    cyc = 0;
    consume();
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    push(tag, 0, st(1, 1, 0, 0, 0, 0));
    tick();
    reset = 1'b0;
    cyc = 0;
    consume();
  endtask

  initial begin
    int t;
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    reset = 1'b1;
    sup.lock = 1'b0;

    // Normal lock: lock rises at cycle 10, release at 10 + 2 + 1 + 8.
    do_reset();
    push("norm_prst_end", 3,  st(1, 1, 0, 0, 0, 0));
    push("norm_wait",     4,  st(0, 1, 0, 0, 0, 0));
    run_to(10);
    sup.lock = 1'b1;
    push("norm_pre_rel",  20, st(0, 1, 0, 0, 0, 0));
    push("norm_release",  21, st(0, 0, 1, 0, 0, 0));
    run_to(21);

    // Lock glitch during STAB returns to WAIT; release 11 cycles after the second rise.
    do_reset();
    run_to(10);
    sup.lock = 1'b1;
    run_to(15);
    sup.lock = 1'b0;
    run_to(17);
    sup.lock = 1'b1;
    push("glitch_no_early", 21, st(0, 1, 0, 0, 0, 0));
    push("glitch_pre_rel",  27, st(0, 1, 0, 0, 0, 0));
    push("glitch_release",  28, st(0, 0, 1, 0, 0, 0));
    run_to(28);

    // Lock synchronised on the same cycle as the timeout: lock wins, no retry pulse.
    do_reset();
    run_to(33);
    sup.lock = 1'b1;
    push("simul_tmo_cyc",  35, st(0, 1, 0, 0, 0, 0));
    push("simul_no_retry", 36, st(0, 1, 0, 0, 0, 0));
    push("simul_pre_rel",  43, st(0, 1, 0, 0, 0, 0));
    push("simul_release",  44, st(0, 0, 1, 0, 0, 0));
    run_to(44);

    // One timeout, then lock; a later 1-cycle lock loss clears retry_cnt and counts a loss.
    do_reset();
    push("loss_retry_prst", 36, st(1, 1, 0, 0, 1, 0));
    push("loss_retry_wait", 40, st(0, 1, 0, 0, 1, 0));
    run_to(45);
    sup.lock = 1'b1;
    push("loss_run_retry1", 56, st(0, 0, 1, 0, 1, 0));
    run_to(60);
    sup.lock = 1'b0;
    run_to(61);
    sup.lock = 1'b1;
    push("loss_still_run", 62, st(0, 0, 1, 0, 1, 0));
    push("loss_prst_first", 63, st(1, 1, 0, 0, 0, 1));
    push("loss_prst_last",  66, st(1, 1, 0, 0, 0, 1));
    push("loss_wait",       67, st(0, 1, 0, 0, 0, 1));
    push("loss_pre_rerun",  75, st(0, 1, 0, 0, 0, 1));
    push("loss_rerun",      76, st(0, 0, 1, 0, 0, 1));
    run_to(76);

    // 259 further loss events: loss_cnt saturates at 255.
    for (int i = 0; i < 259; i++) begin
      t = cyc;
      sup.lock = 1'b0;
      run_to(t + 1);
      sup.lock = 1'b1;
      if (i == 252) push("loss_cnt_254", t + 20, st(0, 0, 1, 0, 0, 254));
      run_to(t + 20);
    end
    push("loss_saturated", cyc + 1, st(0, 0, 1, 0, 0, 255));
    run_to(cyc + 1);

    // Reset pulsed in STAB restores reset values; then a 4-cycle pll_reset pulse.
    t = cyc;
    sup.lock = 1'b0;
    run_to(t + 1);
    sup.lock = 1'b1;
    push("stab_prst_sat", t + 3,  st(1, 1, 0, 0, 0, 255));
    push("stab_in_stab",  t + 10, st(0, 1, 0, 0, 0, 255));
    run_to(t + 10);
    pulse_reset("stab_reset_vals");
    push("stab_pulse_end", 3,  st(1, 1, 0, 0, 0, 0));
    push("stab_pulse_off", 4,  st(0, 1, 0, 0, 0, 0));
    push("stab_pre_rel",   12, st(0, 1, 0, 0, 0, 0));
    push("stab_release",   13, st(0, 0, 1, 0, 0, 0));
    run_to(13);

    // No lock ever: three 4-cycle pulses, retry_cnt 1 then 2, then FAIL.
    do_reset();
    push("nolock_tmo1",   35,  st(0, 1, 0, 0, 0, 0));
    push("nolock_p2_on",  36,  st(1, 1, 0, 0, 1, 0));
    push("nolock_p2_end", 39,  st(1, 1, 0, 0, 1, 0));
    push("nolock_p2_off", 40,  st(0, 1, 0, 0, 1, 0));
    push("nolock_p3_pre", 71,  st(0, 1, 0, 0, 1, 0));
    push("nolock_p3_on",  72,  st(1, 1, 0, 0, 2, 0));
    push("nolock_p3_end", 75,  st(1, 1, 0, 0, 2, 0));
    push("nolock_p3_off", 76,  st(0, 1, 0, 0, 2, 0));
    push("nolock_pre_fl", 107, st(0, 1, 0, 0, 2, 0));
    push("nolock_fail",   108, st(0, 1, 0, 1, 2, 0));
    run_to(110);
    sup.lock = 1'b1;
    push("fail_sticky", 200, st(0, 1, 0, 1, 2, 0));
    run_to(200);
    sup.lock = 1'b0;
    pulse_reset("fail_reset_vals");
    push("fail_pulse_end", 3,  st(1, 1, 0, 0, 0, 0));
    push("fail_pulse_off", 4,  st(0, 1, 0, 0, 0, 0));
    push("fail_retry_on",  39, st(1, 1, 0, 0, 1, 0));
    run_to(40);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $error("FAIL %s: never checked, expected %h at cycle %0d", e.tag, e.exp, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
